// File: rtl/accel_arb_pkg.sv
// ---------------------------------------------------------------------------
// accel_arb_pkg
// Shared types for the accelerator memory-port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   op_t    : latched transaction kind (OP_RD, OP_WR)
// ---------------------------------------------------------------------------
package accel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage : accel_arb_pkg

// File: rtl/accel_mem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority picker.
// The search starts at the channel after i_last_grant and wraps around, so the
// channel granted last has the lowest priority on the next pick.
// Ports:
//   i_req        in  NUM_CH  request vector
//   i_last_grant in  IDX_W   channel granted most recently
//   o_valid      out 1       at least one request present
//   o_idx        out IDX_W   winning channel (0 when o_valid is low)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last_grant,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    int w_cand;

    // Walk the offsets from farthest to nearest; the last hit written is the
    // nearest requester after i_last_grant, which is the round-robin winner.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand = (int'(i_last_grant) + k) % NUM_CH;
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule : rr_picker

// File: rtl/accel_mem_arbiter.sv
// ---------------------------------------------------------------------------
// accel_mem_arbiter
// Round-robin arbiter between NUM_CH accelerator channels and the CPU's single
// accelerator memory port. One transaction is in flight at a time: it is
// latched on grant, held on the CPU side until completion (or timeout), and
// answered with a one-cycle per-channel pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_ch_wrt_en/rd_en   per-channel level requests (write wins if both)
//   i_ch_addr           flattened NUM_CH x ADDR_W addresses
//   i_ch_wrt_data       flattened NUM_CH x WDATA_W write data
//   o_ch_wrt_done       one-cycle write-complete pulse per channel
//   o_ch_rd_valid       one-cycle read-valid pulse per channel
//   o_ch_err            one-cycle timeout-abort pulse per channel
//   o_ch_rd_data        last completed read line, broadcast to all channels
//   o_accel_*           registered drive towards the CPU port
//   i_accel_*           completion handshake and read data from the CPU
//   o_grant_id          current / last granted channel
//   o_busy              high while a transaction is in BUSY or RESP
// ---------------------------------------------------------------------------
module accel_mem_arbiter
    import accel_arb_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int ADDR_W  = 16,
    parameter  int WDATA_W = 32,
    parameter  int RDATA_W = 512,
    parameter  int TIMEOUT = 1024,
    localparam int IDX_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         i_ch_wrt_en,
    input  logic [NUM_CH-1:0]         i_ch_rd_en,
    input  logic [NUM_CH*ADDR_W-1:0]  i_ch_addr,
    input  logic [NUM_CH*WDATA_W-1:0] i_ch_wrt_data,
    output logic [NUM_CH-1:0]         o_ch_wrt_done,
    output logic [NUM_CH-1:0]         o_ch_rd_valid,
    output logic [NUM_CH-1:0]         o_ch_err,
    output logic [RDATA_W-1:0]        o_ch_rd_data,
    output logic [ADDR_W-1:0]         o_accel_addr,
    output logic [WDATA_W-1:0]        o_accel_wrt_data,
    output logic                      o_accel_wrt_en,
    output logic                      o_accel_rd_en,
    input  logic                      i_accel_wrt_done,
    input  logic                      i_accel_rd_valid,
    input  logic [RDATA_W-1:0]        i_accel_rd_data,
    output logic [IDX_W-1:0]          o_grant_id,
    output logic                      o_busy
);

    // Counter must hold the value TIMEOUT itself; keep one bit when disabled.
    localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CH - 1);

    // Unpacked views of the flattened channel buses.
    logic [ADDR_W-1:0]  w_ch_addr  [NUM_CH];
    logic [WDATA_W-1:0] w_ch_wdata [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_ch_addr[gi]  = i_ch_addr[gi*ADDR_W +: ADDR_W];
        assign w_ch_wdata[gi] = i_ch_wrt_data[gi*WDATA_W +: WDATA_W];
    end

    // Registered state
    state_t              r_state;
    op_t                 r_op;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [WDATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [RDATA_W-1:0]  r_rd_data;
    logic                r_wrt_en;
    logic                r_rd_en;
    logic [NUM_CH-1:0]   r_wrt_done;
    logic [NUM_CH-1:0]   r_rd_valid;
    logic [NUM_CH-1:0]   r_err;

    // Next-state values
    state_t              w_state_next;
    op_t                 w_op_next;
    logic [IDX_W-1:0]    w_grant_next;
    logic [IDX_W-1:0]    w_last_grant_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [WDATA_W-1:0]  w_wdata_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [RDATA_W-1:0]  w_rd_data_next;
    logic                w_wrt_en_next;
    logic                w_rd_en_next;
    logic [NUM_CH-1:0]   w_wrt_done_next;
    logic [NUM_CH-1:0]   w_rd_valid_next;
    logic [NUM_CH-1:0]   w_err_next;

    logic [NUM_CH-1:0]   w_req;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;

    assign w_req = i_ch_wrt_en | i_ch_rd_en;

    rr_picker #(
        .NUM_CH(NUM_CH)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    always_comb begin
        w_state_next      = r_state;
        w_op_next         = r_op;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_cnt_next        = r_cnt;
        w_rd_data_next    = r_rd_data;
        w_wrt_en_next     = r_wrt_en;
        w_rd_en_next      = r_rd_en;
        // Response pulses are single-cycle: cleared unless set below.
        w_wrt_done_next   = '0;
        w_rd_valid_next   = '0;
        w_err_next        = '0;

        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next  = BUSY;
                    w_grant_next  = w_pick_idx;
                    w_addr_next   = w_ch_addr[w_pick_idx];
                    w_wdata_next  = w_ch_wdata[w_pick_idx];
                    w_cnt_next    = '0;
                    // A channel asking for both gets its write first; its read
                    // request stays up and is arbitrated again afterwards.
                    w_op_next     = i_ch_wrt_en[w_pick_idx] ? OP_WR : OP_RD;
                    w_wrt_en_next = i_ch_wrt_en[w_pick_idx];
                    w_rd_en_next  = ~i_ch_wrt_en[w_pick_idx];
                end
            end

            BUSY: begin
                // Only the completion matching the latched op is honoured.
                if (r_op == OP_WR && i_accel_wrt_done) begin
                    w_state_next             = RESP;
                    w_wrt_en_next            = 1'b0;
                    w_rd_en_next             = 1'b0;
                    w_wrt_done_next[r_grant] = 1'b1;
                end else if (r_op == OP_RD && i_accel_rd_valid) begin
                    w_state_next             = RESP;
                    w_wrt_en_next            = 1'b0;
                    w_rd_en_next             = 1'b0;
                    w_rd_valid_next[r_grant] = 1'b1;
                    w_rd_data_next           = i_accel_rd_data;
                end else if (TIMEOUT > 0 && r_cnt == CNT_MAX) begin
                    w_state_next        = RESP;
                    w_wrt_en_next       = 1'b0;
                    w_rd_en_next        = 1'b0;
                    w_err_next[r_grant] = 1'b1;
                end else if (TIMEOUT > 0) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            RESP: begin
                w_last_grant_next = r_grant;
                w_state_next      = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= OP_RD;
            r_grant      <= '0;
            r_last_grant <= LAST_RST;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rd_data    <= '0;
            r_wrt_en     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wrt_done   <= '0;
            r_rd_valid   <= '0;
            r_err        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_cnt        <= w_cnt_next;
            r_rd_data    <= w_rd_data_next;
            r_wrt_en     <= w_wrt_en_next;
            r_rd_en      <= w_rd_en_next;
            r_wrt_done   <= w_wrt_done_next;
            r_rd_valid   <= w_rd_valid_next;
            r_err        <= w_err_next;
        end
    end

    assign o_ch_wrt_done    = r_wrt_done;
    assign o_ch_rd_valid    = r_rd_valid;
    assign o_ch_err         = r_err;
    assign o_ch_rd_data     = r_rd_data;
    assign o_accel_addr     = r_addr;
    assign o_accel_wrt_data = r_wdata;
    assign o_accel_wrt_en   = r_wrt_en;
    assign o_accel_rd_en    = r_rd_en;
    assign o_grant_id       = r_grant;
    assign o_busy           = (r_state != IDLE);

endmodule : accel_mem_arbiter

// File: tb/tb_accel_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_accel_mem_arbiter
// Directed + randomized bench. A transaction-level model (pending request
// sets, round-robin pick, fixed cycle timeline) predicts every DUT output.
// ---------------------------------------------------------------------------
module tb_accel_mem_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int RW  = 512;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_wrt_en, ch_rd_en;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wrt_data;
    logic [NCH-1:0]    ch_wrt_done, ch_rd_valid, ch_err;
    logic [RW-1:0]     ch_rd_data;
    logic [AW-1:0]     accel_addr;
    logic [DW-1:0]     accel_wrt_data;
    logic              accel_wrt_en, accel_rd_en;
    logic              accel_wrt_done, accel_rd_valid;
    logic [RW-1:0]     accel_rd_data;
    logic [1:0]        grant_id;
    logic              busy;

    accel_mem_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .WDATA_W(DW), .RDATA_W(RW), .TIMEOUT(TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_ch_wrt_en      (ch_wrt_en),
        .i_ch_rd_en       (ch_rd_en),
        .i_ch_addr        (ch_addr),
        .i_ch_wrt_data    (ch_wrt_data),
        .o_ch_wrt_done    (ch_wrt_done),
        .o_ch_rd_valid    (ch_rd_valid),
        .o_ch_err         (ch_err),
        .o_ch_rd_data     (ch_rd_data),
        .o_accel_addr     (accel_addr),
        .o_accel_wrt_data (accel_wrt_data),
        .o_accel_wrt_en   (accel_wrt_en),
        .o_accel_rd_en    (accel_rd_en),
        .i_accel_wrt_done (accel_wrt_done),
        .i_accel_rd_valid (accel_rd_valid),
        .i_accel_rd_data  (accel_rd_data),
        .o_grant_id       (grant_id),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    int total;
    int bad;

    // Model state
    logic [NCH-1:0] wr_pend, rd_pend;
    logic [AW-1:0]  m_addr  [NCH];
    logic [DW-1:0]  m_wdata [NCH];
    int             last_g;
    logic [RW-1:0]  m_rdata;
    int             fair_exp [6];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand512();
        logic [RW-1:0] v;
        for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (last_g + k) % NCH;
            if (wr_pend[c] || rd_pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        ch_wrt_en = wr_pend;
        ch_rd_en  = rd_pend;
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW]     = m_addr[i];
            ch_wrt_data[i*DW +: DW] = m_wdata[i];
        end
    endtask

    // Entered #1 into an IDLE cycle with requests already driven; returns #1
    // into the IDLE cycle following the response pulse.
    task automatic run_txn(input int lat, input bit tmo, input bit keep,
                           input logic [RW-1:0] rdat, output int w);
        bit            is_wr;
        int            n;
        logic [NCH-1:0] onehot;
        w     = pick();
        is_wr = wr_pend[w];
        n     = tmo ? TMO + 1 : lat;
        onehot = '0;
        onehot[w] = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pulses", {ch_err, ch_rd_valid, ch_wrt_done}, 0);
        @(posedge clk); #1;
        for (int c = 1; c <= n; c++) begin
            accel_wrt_done = 1'b0;
            accel_rd_valid = 1'b0;
            accel_rd_data  = rand512();
            if (!tmo && c == lat) begin
                if (is_wr) accel_wrt_done = 1'b1;
                else       accel_rd_valid = 1'b1;
                accel_rd_data = rdat;
            end else if ($urandom_range(0, 2) == 0) begin
                if (is_wr) accel_rd_valid = 1'b1;
                else       accel_wrt_done = 1'b1;
            end
            @(negedge clk);
            chk("busy", busy, 1);
            chk("wrt_en", accel_wrt_en, is_wr);
            chk("rd_en", accel_rd_en, !is_wr);
            chk("grant_id", grant_id, w);
            chk("accel_addr", accel_addr, m_addr[w]);
            if (is_wr) chk("accel_wdata", accel_wrt_data, m_wdata[w]);
            chk("busy_pulses", {ch_err, ch_rd_valid, ch_wrt_done}, 0);
            chk("rd_data_hold", ch_rd_data, m_rdata);
            @(posedge clk); #1;
        end
        // RESP cycle; completions here must be ignored
        accel_wrt_done = tmo;
        accel_rd_valid = tmo;
        if (!tmo && !is_wr) m_rdata = rdat;
        @(negedge clk);
        chk("resp_done",  ch_wrt_done, (!tmo && is_wr)  ? onehot : '0);
        chk("resp_valid", ch_rd_valid, (!tmo && !is_wr) ? onehot : '0);
        chk("resp_err",   ch_err,      tmo ? onehot : '0);
        chk("resp_en", {accel_wrt_en, accel_rd_en}, 0);
        chk("resp_busy", busy, 1);
        chk("resp_rd_data", ch_rd_data, m_rdata);
        @(posedge clk); #1;
        accel_wrt_done = 1'b0;
        accel_rd_valid = 1'b0;
        last_g = w;
        if (!keep) begin
            if (is_wr) wr_pend[w] = 1'b0;
            else       rd_pend[w] = 1'b0;
        end
        drive_reqs();
        $display("txn ch=%0d op=%s lat=%0d tmo=%0d total=%0d bad=%0d",
                 w, is_wr ? "WR" : "RD", n, tmo, total, bad);
    endtask

    task automatic add_random_reqs();
        for (int c = 0; c < NCH; c++) begin
            if (!wr_pend[c] && !rd_pend[c] && $urandom_range(0, 1) == 1) begin
                m_addr[c]  = AW'($urandom());
                m_wdata[c] = $urandom();
                case ($urandom_range(0, 2))
                    0:       wr_pend[c] = 1'b1;
                    1:       rd_pend[c] = 1'b1;
                    default: begin wr_pend[c] = 1'b1; rd_pend[c] = 1'b1; end
                endcase
            end
        end
        if ((wr_pend | rd_pend) == '0) begin
            int c;
            c = $urandom_range(0, NCH-1);
            m_addr[c]  = AW'($urandom());
            m_wdata[c] = $urandom();
            wr_pend[c] = 1'b1;
        end
        drive_reqs();
    endtask

    task automatic drain();
        int g;
        while ((wr_pend | rd_pend) != '0) run_txn($urandom_range(1, 8), 0, 0, rand512(), g);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, {accel_wrt_en, accel_rd_en}, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_addr"}, accel_addr, 0);
        chk({tag, "_wdata"}, accel_wrt_data, 0);
        chk({tag, "_rdata"}, ch_rd_data, 0);
        chk({tag, "_pulses"}, {ch_err, ch_rd_valid, ch_wrt_done}, 0);
    endtask

    initial begin
        int g;
        logic [RW-1:0] a5;
        total = 0;
        bad   = 0;
        fair_exp = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        accel_wrt_done = 1'b0;
        accel_rd_valid = 1'b0;
        accel_rd_data  = '0;
        wr_pend = '0;
        rd_pend = '0;
        last_g  = NCH - 1;
        m_rdata = '0;
        for (int i = 0; i < NCH; i++) begin m_addr[i] = '0; m_wdata[i] = '0; end
        drive_reqs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fairness: all channels keep requesting
        for (int c = 0; c < NCH; c++) begin
            m_addr[c]  = AW'($urandom());
            m_wdata[c] = $urandom();
            if ($urandom_range(0, 1) == 1) wr_pend[c] = 1'b1;
            else                           rd_pend[c] = 1'b1;
        end
        drive_reqs();
        for (int i = 0; i < 6; i++) begin
            run_txn($urandom_range(1, 4), 0, 1, rand512(), g);
            chk("fair_order", grant_id, fair_exp[i]);
        end
        wr_pend = '0;
        rd_pend = '0;
        drive_reqs();

        // Single write ch2, completion 3 cycles into BUSY
        wr_pend[2] = 1'b1;
        m_addr[2]  = 16'h0040;
        m_wdata[2] = 32'hDEADBEEF;
        drive_reqs();
        run_txn(3, 0, 0, rand512(), g);

        // Read ch1 returning A5 pattern, then check it is held
        a5 = {64{8'hA5}};
        rd_pend[1] = 1'b1;
        m_addr[1]  = 16'h0100;
        drive_reqs();
        run_txn(2, 0, 0, a5, g);
        repeat (3) begin
            @(negedge clk);
            chk("a5_hold", ch_rd_data, a5);
            @(posedge clk); #1;
        end

        // Both enables on ch0: write first, read later
        wr_pend[0] = 1'b1;
        rd_pend[0] = 1'b1;
        m_addr[0]  = 16'h0200;
        m_wdata[0] = $urandom();
        drive_reqs();
        run_txn(2, 0, 0, rand512(), g);
        chk("dual_rd_pending", ch_rd_en[0], 1);
        run_txn(1, 0, 0, rand512(), g);

        // Timeout on ch3 write, late completion ignored
        wr_pend[3] = 1'b1;
        m_addr[3]  = 16'h0333;
        m_wdata[3] = $urandom();
        drive_reqs();
        run_txn(0, 1, 0, rand512(), g);
        accel_wrt_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_done_busy", busy, 0);
            chk("late_done_pulses", {ch_err, ch_rd_valid, ch_wrt_done}, 0);
            @(posedge clk); #1;
        end
        accel_wrt_done = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            add_random_reqs();
            run_txn($urandom_range(1, 8), 0, 0, rand512(), g);
        end
        drain();

        // Make sure read data is nonzero so its reset is observable
        rd_pend[2] = 1'b1;
        m_addr[2]  = 16'h0222;
        drive_reqs();
        run_txn(1, 0, 0, {RW{1'b1}}, g);

        // Asynchronous reset in BUSY
        wr_pend[1] = 1'b1;
        m_addr[1]  = 16'h0111;
        m_wdata[1] = $urandom();
        drive_reqs();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        wr_pend = '0;
        rd_pend = '0;
        drive_reqs();
        @(posedge clk); #1;
        rst_n   = 1'b1;
        last_g  = NCH - 1;
        m_rdata = '0;

        // Simultaneous ch0 and ch3 after reset: ch0 first
        rd_pend[0] = 1'b1;
        rd_pend[3] = 1'b1;
        m_addr[0]  = 16'h0A00;
        m_addr[3]  = 16'h0A03;
        drive_reqs();
        run_txn(2, 0, 0, rand512(), g);
        chk("post_rst_first", ch_rd_en, 4'b1000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_accel_mem_arbiter

// File: doc/accel_mem_arbiter.md
# accel_mem_arbiter

Parametrised N-channel arbiter between a bank of accelerators and the CPU's single accelerator memory port (address, write data, write/read enables, write-done, read-valid, 512-bit read data). It replaces the single-client combinational address mux with round-robin arbitration. It holds each transaction registered until the CPU side completes it, and returns per-channel done/valid pulses. A timeout aborts a transaction that never completes.

## Interface
Parameters:
- NUM_CH, 4, number of accelerator channels (≥2)
- ADDR_W, 16, address width
- WDATA_W, 32, write data width
- RDATA_W, 512, read data width (one cache line)
- TIMEOUT, 1024, max BUSY cycles before abort; 0 disables timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- ch_wrt_en  in  NUM_CH  per-channel write request (level)
- ch_rd_en  in  NUM_CH  per-channel read request (level)
- ch_addr  in  NUM_CH×ADDR_W  per-channel address
- ch_wrt_data  in  NUM_CH×WDATA_W  per-channel write data
- ch_wrt_done  out  NUM_CH  one-cycle write-complete pulse
- ch_rd_valid  out  NUM_CH  one-cycle read-data-valid pulse
- ch_err  out  NUM_CH  one-cycle timeout-abort pulse
- ch_rd_data  out  RDATA_W  registered read data, broadcast to all channels
- accel_addr  out  ADDR_W  to CPU accelerator port
- accel_wrt_data  out  WDATA_W  to CPU
- accel_wrt_en  out  1  to CPU
- accel_rd_en  out  1  to CPU
- accel_wrt_done  in  1  from CPU, write complete
- accel_rd_valid  in  1  from CPU, read data valid
- accel_rd_data  in  RDATA_W  from CPU
- grant_id  out  $clog2(NUM_CH)  index of current/last granted channel
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any ch_wrt_en|ch_rd_en is set, pick the winner round-robin. Search starts at last_grant+1 mod NUM_CH. Latch addr, wrt_data, op and grant_id, then go to BUSY. Otherwise stay in IDLE.
- Op select: write wins if a channel asserts both enables. The read stays pending and is arbitrated again later.
- BUSY: drive accel_addr/accel_wrt_data from the latched registers. Hold accel_wrt_en or accel_rd_en high.
  - Write op: accel_wrt_done → RESP and pulse ch_wrt_done[grant].
  - Read op: accel_rd_valid → RESP, capture accel_rd_data into ch_rd_data and pulse ch_rd_valid[grant].
  - Completion of the wrong kind (rd_valid during a write, or the reverse) is ignored.
- Timeout: a cycle counter runs in BUSY. When it reaches TIMEOUT (TIMEOUT>0) → RESP with ch_err[grant] pulsed instead of done/valid.
- RESP: one cycle; response pulse high; enables low. last_grant ← grant_id; go to IDLE.
- Requester rule: hold request, addr and data stable until the response pulse. Deassert at the clock edge ending the pulse cycle.
- accel_wrt_done/accel_rd_valid are ignored in IDLE and RESP.
- Reset, including mid-transaction: state IDLE, all outputs 0, ch_rd_data 0, counter 0. last_grant = NUM_CH-1, so channel 0 has first priority.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: accel_*_en high (registered outputs).
- Cycle k: completion input seen.
- Cycle k+1: RESP; pulse and ch_rd_data valid; enables low.
- Cycle k+2: IDLE, new arbitration.
- Minimum request-to-pulse latency 2 cycles (completion in cycle 1). Back-to-back grants every 3 cycles minimum.
- Timeout: abort pulse in cycle TIMEOUT+1 after entry to BUSY. Counter width $clog2(TIMEOUT+1).
- ch_rd_data holds its value until the next read completion.

## Structure
- Package accel_arb_pkg: state enum {IDLE, BUSY, RESP}, op enum {OP_RD, OP_WR}.
- Sub-module rr_picker: combinational round-robin priority picker over NUM_CH requests, with last_grant input. Outputs valid and index.
- Top: FSM, latches, timeout counter.

## Test plan
- Single write: ch2 wrt_en, addr 0x0040, data 0xDEADBEEF; CPU done 3 cycles later → accel_wrt_en high cycles 1–3; ch_wrt_done[2] pulses cycle 4; grant_id=2.
- Read: ch1 read addr 0x0100; rd_valid with data 0xA5…A5 → ch_rd_valid[1] one cycle; ch_rd_data=0xA5…A5 held afterwards.
- Fairness: all 4 channels request continuously, each re-requesting after its pulse → grant order 0,1,2,3,0,1.
- Both enables on ch0 → write serviced first; read granted on a later arbitration; ch0 gets ch_wrt_done, then later ch_rd_valid.
- Timeout with TIMEOUT=8: no completion → ch_err[grant] pulse 9 cycles after BUSY entry; enables drop; a late accel_wrt_done is ignored.
- rst_n asserted in BUSY → outputs 0 immediately. After release, simultaneous requests on ch0 and ch3 → ch0 granted.
